// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
`timescale 1ns/1ps
package keypad_pkg;

  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 4;
  localparam int IDX_W      = 2;

  localparam logic [KEY_COLS-1:0] COL_RESET = 4'b1110;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED
  } state_e;

  // Lowest-index active-low row wins when several rows are down together.
  function automatic idx_t lowest_low(input logic [KEY_ROWS-1:0] rows);
    lowest_low = '0;
    for (int i = KEY_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) lowest_low = idx_t'(i);
    end
  endfunction

  function automatic logic [KEY_COLS-1:0] col_drive(input idx_t idx);
    col_drive = ~(KEY_COLS'(1) << idx);
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Parameterised 2-flop synchronizer; resets to all-ones (idle level of pulled-up rows).
`timescale 1ns/1ps
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan on a slow tick, per-key debounce,
// one-cycle KEY_VALID per accepted press and a KEY_HELD level until release.
`timescale 1ns/1ps
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4096,
  parameter int DEBOUNCE_FRAMES = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [KEY_ROWS-1:0]   ROW,
  output logic [KEY_COLS-1:0]   COL,
  output logic [KEY_CODE_W-1:0] KEY_CODE,
  output logic                  KEY_VALID,
  output logic                  KEY_HELD
);

  localparam int TICK_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_FRAMES);

  logic [KEY_ROWS-1:0]   row_s;
  logic [TICK_W-1:0]     tick_q, tick_d;
  state_e                state_q, state_d;
  idx_t                  col_idx_q, col_idx_d;
  logic [KEY_COLS-1:0]   col_q, col_d;
  idx_t                  cap_row_q, cap_row_d;
  idx_t                  cap_col_q, cap_col_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_held_q, key_held_d;

  logic                  tick;
  logic                  cap_down;
  logic                  accept;
  logic [CNT_W-1:0]      count_inc;

  keypad_sync #(.WIDTH(KEY_ROWS)) u_sync (
    .clk   (CLK),
    .reset (RESET),
    .d     (ROW),
    .q     (row_s)
  );

  assign tick      = (tick_q == TICK_LAST);
  assign cap_down  = ~row_s[cap_row_q];
  assign count_inc = count_q + 1'b1;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    tick_d      = tick ? '0 : tick_q + 1'b1;
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    cap_row_d   = cap_row_q;
    cap_col_d   = cap_col_q;
    count_d     = count_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;

    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (&row_s) begin
            col_idx_d = col_idx_q + 1'b1;
          end else begin
            cap_row_d = lowest_low(row_s);
            cap_col_d = col_idx_q;
            if (DEBOUNCE_FRAMES == 1) begin
              accept = 1'b1;
            end else begin
              count_d = CNT_W'(1);
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (cap_down) begin
            if (count_inc == CNT_DONE) accept = 1'b1;
            else count_d = count_inc;
          end else begin
            count_d   = '0;
            col_idx_d = col_idx_q + 1'b1;
            state_d   = SCAN;
          end
        end
        PRESSED: begin
          if (!cap_down) begin
            if (count_inc == CNT_DONE) begin
              count_d    = '0;
              key_held_d = 1'b0;
              col_idx_d  = col_idx_q + 1'b1;
              state_d    = SCAN;
            end else begin
              count_d = count_inc;
            end
          end else begin
            count_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    if (accept) begin
      state_d     = PRESSED;
      key_code_d  = {cap_row_d, cap_col_d};
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
      count_d     = '0;
    end

    // Column drive is registered from the next index so COL never glitches.
    col_d = col_drive(col_idx_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tick_q      <= '0;
      state_q     <= SCAN;
      col_idx_q   <= '0;
      col_q       <= COL_RESET;
      cap_row_q   <= '0;
      cap_col_q   <= '0;
      count_q     <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      cap_row_q   <= cap_row_d;
      cap_col_q   <= cap_col_d;
      count_q     <= count_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign COL       = col_q;
  assign KEY_CODE  = key_code_q;
  assign KEY_VALID = key_valid_q;
  assign KEY_HELD  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix model and a KEY_VALID scoreboard.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SCAN_DIV        = 8;
  localparam int DEBOUNCE_FRAMES = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;
  logic [3:0]  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .ROW       (row),
    .COL       (col),
    .KEY_CODE  (key_code),
    .KEY_VALID (key_valid),
    .KEY_HELD  (key_held)
  );

  always #5 clk = ~clk;

  // Key (r,c) is bit r*4+c; a row reads low only while its key's column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    cycles(n * SCAN_DIV);
  endtask

  // Scoreboard monitor: every KEY_VALID pulse must match the next queued code.
  always @(negedge clk) begin : monitor
    logic [3:0] exp_code;
    if (key_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_valid: code %h seen, no pulse expected (t=%0t)", key_code, $time);
      end else begin
        exp_code = exp_q.pop_front();
        if (key_code !== exp_code) begin
          n_errors++;
          $display("FAIL valid_code: got %h expected %h (t=%0t)", key_code, exp_code, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [3:0] pat [4];
    pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    keys = '0;
    rst  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Test 1: reset values then idle scan, each column for SCAN_DIV cycles
    check("rst_col", col, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", 4'(key_valid), 4'h0);
    check("rst_held", 4'(key_held), 4'h0);
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < SCAN_DIV; k++) begin
        @(negedge clk);
        check($sformatf("idle_col_s%0d_c%0d", s, k), col, pat[s % 4]);
      end
      check($sformatf("idle_held_s%0d", s), 4'(key_held), 4'h0);
      check($sformatf("idle_code_s%0d", s), key_code, 4'h0);
    end
    @(posedge clk);
    #1;

    // Test 2: clean press of (2,1) while column 1 is driven
    check("t2_start_col", col, 4'b1101);
    keys[2*4+1] = 1'b1;
    exp_q.push_back(4'h9);
    ticks(2);
    check("t2_col_frozen", col, 4'b1101);
    check("t2_not_yet_held", 4'(key_held), 4'h0);
    check("t2_not_yet_valid", 4'(key_valid), 4'h0);
    ticks(1);
    check("t2_valid", 4'(key_valid), 4'h1);
    check("t2_code", key_code, 4'h9);
    check("t2_held", 4'(key_held), 4'h1);
    check("t2_col", col, 4'b1101);
    cycles(1);
    check("t2_valid_one_cycle", 4'(key_valid), 4'h0);

    // Test 4: one-tick release glitch rejected, then a real release
    keys = '0;
    cycles(SCAN_DIV - 1);
    check("t4_held_after_1", 4'(key_held), 4'h1);
    keys[2*4+1] = 1'b1;
    ticks(1);
    check("t4_held_repress", 4'(key_held), 4'h1);
    keys = '0;
    ticks(2);
    check("t4_held_after_2", 4'(key_held), 4'h1);
    ticks(1);
    check("t4_released", 4'(key_held), 4'h0);
    check("t4_col_resume", col, 4'b1011);
    check("t4_code_kept", key_code, 4'h9);

    // Test 3: (0,3) bounces for a single tick
    keys[0*4+3] = 1'b1;
    ticks(2);
    check("t3_col", col, 4'b0111);
    keys = '0;
    ticks(1);
    check("t3_col_resume", col, 4'b1110);
    check("t3_held", 4'(key_held), 4'h0);
    check("t3_code_kept", key_code, 4'h9);

    // Test 5: (1,0) and (3,0) together; lowest row wins
    keys[1*4+0] = 1'b1;
    keys[3*4+0] = 1'b1;
    exp_q.push_back(4'h4);
    ticks(3);
    check("t5_valid", 4'(key_valid), 4'h1);
    check("t5_code", key_code, 4'h4);
    check("t5_held", 4'(key_held), 4'h1);
    cycles(1);
    check("t5_valid_one_cycle", 4'(key_valid), 4'h0);
    keys[3*4+0] = 1'b0;
    cycles(SCAN_DIV - 1);
    ticks(2);
    check("t5_other_release_ignored", 4'(key_held), 4'h1);
    check("t5_col_frozen", col, 4'b1110);
    keys[1*4+0] = 1'b0;
    ticks(2);
    check("t5_held_after_2", 4'(key_held), 4'h1);
    ticks(1);
    check("t5_released", 4'(key_held), 4'h0);
    check("t5_col_resume", col, 4'b1101);

    // Test 6: reset in the middle of a debounce
    keys[2*4+2] = 1'b1;
    ticks(2);
    check("t6_col_capture", col, 4'b1011);
    ticks(1);
    check("t6_col_frozen", col, 4'b1011);
    rst  = 1'b1;
    keys = '0;
    cycles(1);
    check("t6_rst_col", col, 4'b1110);
    check("t6_rst_code", key_code, 4'h0);
    check("t6_rst_held", 4'(key_held), 4'h0);
    check("t6_rst_valid", 4'(key_valid), 4'h0);
    rst = 1'b0;
    ticks(4);
    check("t6_scan_wrap", col, 4'b1110);
    check("t6_held_idle", 4'(key_held), 4'h0);

    check("pending_pulses", 4'(exp_q.size()), 4'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
